// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared hazard-control types and the architectural reset PC.
// Used by the hazard sequencer and by the pipeline stage registers.
// No logic here: types and constants only.
package pipe_hazard_ctrl_pkg;

  // Fetch restarts here after reset; the pipeline registers use it too.
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    RUN,
    REDIR_PEND,
    TRAP_WAIT
  } hz_state_t;

  // One field per pipeline register: keep contents, or load a bubble.
  typedef struct packed {
    logic hold;
    logic kill;
  } stage_ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// Stall-cycle and redirect-pulse performance counters.
// Latency: count visible the cycle after the enable; wrap modulo 2^CNT_W.
// No backpressure; only reset clears the counts.
module hz_perf_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_en,
  input  logic             redir_en,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_cnt
);

  // Free-running counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      redirect_cnt <= '0;
    end else begin
      if (stall_en) stall_cycles <= stall_cycles + 1'b1;
      if (redir_en) redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/redirect sequencer: hold, kill and PC redirect for the 5-stage core.
// Latency: controls are combinational; redirect pulses the cycle fetch is idle.
// Backpressure: i_busy defers a redirect; d_busy/mdu_busy freeze the pipe.
module pipe_hazard_ctrl #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(pipe_hazard_ctrl_pkg::RESET_PC),
  parameter int              CNT_W    = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_busy,
  input  logic             d_busy,
  input  logic             mdu_busy,
  input  logic             load_use,
  input  logic             br_valid,
  input  logic [XLEN-1:0]  br_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_target,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  pc_target,
  output logic             hold_F,
  output logic             hold_FD,
  output logic             hold_DE,
  output logic             hold_EM,
  output logic             kill_FD,
  output logic             kill_DE,
  output logic             kill_EM,
  output logic             kill_MW,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_cnt
);

  import pipe_hazard_ctrl_pkg::*;

  hz_state_t       state, state_nxt;
  logic [XLEN-1:0] tgt, tgt_nxt;
  logic            hold_f;
  stage_ctl_t      fd, de, em, mw;
  logic            freeze;

  assign freeze = d_busy | mdu_busy;

  // State and latched redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      tgt   <= RESET_PC;
    end else begin
      state <= state_nxt;
      tgt   <= tgt_nxt;
    end
  end

  // Next state, target latch and all stage controls from state and inputs.
  always_comb begin
    state_nxt   = state;
    tgt_nxt     = tgt;
    pc_redirect = 1'b0;
    pc_target   = tgt;
    hold_f      = 1'b0;
    fd          = '0;
    de          = '0;
    em          = '0;
    mw          = '0;

    case (state)
      RUN: begin
        if (trap_valid && d_busy) begin
          // Trap must wait for MEM to drain; freeze meanwhile.
          tgt_nxt   = trap_target;
          state_nxt = TRAP_WAIT;
          hold_f    = 1'b1;
          fd.hold   = 1'b1;
          de.hold   = 1'b1;
          em.hold   = 1'b1;
          mw.kill   = 1'b1;
        end else if (trap_valid) begin
          fd.kill = 1'b1;
          de.kill = 1'b1;
          em.kill = 1'b1;
          if (i_busy) begin
            tgt_nxt   = trap_target;
            hold_f    = 1'b1;
            state_nxt = REDIR_PEND;
          end else begin
            pc_redirect = 1'b1;
            pc_target   = trap_target;
          end
        end else if (freeze) begin
          // EX is held, so any branch/load-use re-presents next cycle.
          hold_f  = 1'b1;
          fd.hold = 1'b1;
          de.hold = 1'b1;
          em.hold = 1'b1;
          mw.kill = 1'b1;
        end else if (br_valid) begin
          fd.kill = 1'b1;
          de.kill = 1'b1;
          if (i_busy) begin
            tgt_nxt   = br_target;
            hold_f    = 1'b1;
            state_nxt = REDIR_PEND;
          end else begin
            pc_redirect = 1'b1;
            pc_target   = br_target;
          end
        end else if (load_use) begin
          hold_f  = 1'b1;
          fd.hold = 1'b1;
          de.kill = 1'b1;
        end
      end

      REDIR_PEND: begin
        // Keep wrong-path fetches out until the outstanding fetch returns.
        hold_f  = 1'b1;
        fd.kill = 1'b1;
        if (trap_valid) begin
          tgt_nxt = trap_target;
          de.kill = 1'b1;
          em.kill = 1'b1;
        end
        if (!i_busy) begin
          pc_redirect = 1'b1;
          pc_target   = tgt_nxt;
          state_nxt   = RUN;
        end
      end

      TRAP_WAIT: begin
        if (d_busy) begin
          hold_f  = 1'b1;
          fd.hold = 1'b1;
          de.hold = 1'b1;
          em.hold = 1'b1;
          mw.kill = 1'b1;
        end else begin
          fd.kill = 1'b1;
          de.kill = 1'b1;
          em.kill = 1'b1;
          if (i_busy) begin
            hold_f    = 1'b1;
            state_nxt = REDIR_PEND;
          end else begin
            pc_redirect = 1'b1;
            pc_target   = tgt;
            state_nxt   = RUN;
          end
        end
      end

      default: state_nxt = RUN;
    endcase

    // A bubble wins over holding stale contents.
    fd.hold = fd.hold & ~fd.kill;
    de.hold = de.hold & ~de.kill;
    em.hold = em.hold & ~em.kill;

    // During reset the whole pipe is flushed and fetch is left alone.
    if (reset) begin
      pc_redirect = 1'b0;
      hold_f      = 1'b0;
      fd          = '{hold: 1'b0, kill: 1'b1};
      de          = '{hold: 1'b0, kill: 1'b1};
      em          = '{hold: 1'b0, kill: 1'b1};
      mw          = '{hold: 1'b0, kill: 1'b1};
    end
  end

  assign hold_F  = hold_f;
  assign hold_FD = fd.hold;
  assign hold_DE = de.hold;
  assign hold_EM = em.hold;
  assign kill_FD = fd.kill;
  assign kill_DE = de.kill;
  assign kill_EM = em.kill;
  assign kill_MW = mw.kill | mw.hold;

  hz_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk         (clk),
    .reset       (reset),
    .stall_en    (hold_f),
    .redir_en    (pc_redirect),
    .stall_cycles(stall_cycles),
    .redirect_cnt(redirect_cnt)
  );

endmodule
